// File: rtl/pb_debounce_encoder.sv
// Pushbutton front end: synchronizes and debounces 15 raw buttons, encodes the
// lowest pressed note key, and steps the mode/octave selectors on button presses.
module pb_debounce_encoder #(
    parameter int SAMPLE_DIV     = 1000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] pb,
    output logic [3:0]  note_idx,
    output logic        note_valid,
    output logic        note_strobe,
    output logic [1:0]  mode_out,
    output logic [1:0]  octave
);

    localparam int          NUM_PB     = 15;
    localparam int          NUM_NOTES  = 13;
    localparam logic [15:0] PRESC_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [2:0]  CNT_LAST   = 3'(STABLE_SAMPLES - 1);

    logic [NUM_PB-1:0]       sync1_q, sync1_d;
    logic [NUM_PB-1:0]       sync2_q, sync2_d;
    logic [15:0]             presc_q, presc_d;
    logic [NUM_PB-1:0][2:0]  cnt_q, cnt_d;
    logic [NUM_PB-1:0]       deb_q, deb_d;
    logic [NUM_PB-1:0]       deb_prev_q, deb_prev_d;
    logic [3:0]              note_idx_q, note_idx_d;
    logic                    note_valid_q, note_valid_d;
    logic                    note_strobe_q, note_strobe_d;
    logic [1:0]              mode_q, mode_d;
    logic [1:0]              octave_q, octave_d;

    logic                    sample_tick;
    logic [NUM_PB-1:0]       rise;
    logic [3:0]              enc_idx;
    logic                    any_note;

    // Synchronizer, prescaler and per-bit agreement counters.
    always_comb begin
        sync1_d     = pb;
        sync2_d     = sync1_q;
        sample_tick = (presc_q == PRESC_LAST);
        presc_d     = sample_tick ? 16'd0 : presc_q + 16'd1;
        cnt_d       = cnt_q;
        deb_d       = deb_q;
        if (sample_tick) begin
            for (int i = 0; i < NUM_PB; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_d[i] = 3'd0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                    cnt_d[i] = 3'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 3'd1;
                end
            end
        end
    end

    // Lowest-index note key wins; scanning downward lets the last hit stand.
    always_comb begin
        enc_idx  = 4'd0;
        any_note = |deb_q[NUM_NOTES-1:0];
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (deb_q[i]) begin
                enc_idx = 4'(i);
            end
        end
    end

    always_comb begin
        deb_prev_d    = deb_q;
        rise          = deb_q & ~deb_prev_q;
        note_valid_d  = any_note;
        note_idx_d    = any_note ? enc_idx : note_idx_q;
        note_strobe_d = any_note && (!note_valid_q || (enc_idx != note_idx_q));
        mode_d        = rise[13] ? mode_q + 2'd1 : mode_q;
        octave_d      = octave_q;
        if (rise[14]) begin
            octave_d = (octave_q == 2'd2) ? 2'd0 : octave_q + 2'd1;
        end
    end

    // NOTE: every piece of state is cleared on reset, including the counter
    // array, so a reset mid-debounce can never complete a stale flip afterward.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            presc_q       <= '0;
            cnt_q         <= '0;
            deb_q         <= '0;
            deb_prev_q    <= '0;
            note_idx_q    <= '0;
            note_valid_q  <= 1'b0;
            note_strobe_q <= 1'b0;
            mode_q        <= '0;
            octave_q      <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            deb_q         <= deb_d;
            deb_prev_q    <= deb_prev_d;
            note_idx_q    <= note_idx_d;
            note_valid_q  <= note_valid_d;
            note_strobe_q <= note_strobe_d;
            mode_q        <= mode_d;
            octave_q      <= octave_d;
        end
    end

    assign note_idx    = note_idx_q;
    assign note_valid  = note_valid_q;
    assign note_strobe = note_strobe_q;
    assign mode_out    = mode_q;
    assign octave      = octave_q;

endmodule

// File: tb/tb_pb_debounce_encoder.sv
// Scoreboard bench: stimulus queues the expected output events, a monitor
// compares every strobe or output change against the head of the queue.
module tb_pb_debounce_encoder;

    typedef struct packed {
        logic       strobe;
        logic       valid;
        logic [3:0] idx;
        logic [1:0] mode;
        logic [1:0] oct;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] pb = '0;
    logic [3:0]  note_idx;
    logic        note_valid;
    logic        note_strobe;
    logic [1:0]  mode_out;
    logic [1:0]  octave;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    bit  mon_en = 1'b0;

    pb_debounce_encoder #(.SAMPLE_DIV(4), .STABLE_SAMPLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pb         (pb),
        .note_idx   (note_idx),
        .note_valid (note_valid),
        .note_strobe(note_strobe),
        .mode_out   (mode_out),
        .octave     (octave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic expect_ev(input logic s, input logic v, input logic [3:0] i,
                             input logic [1:0] m, input logic [1:0] o);
        ev_t e;
        e = '{strobe: s, valid: v, idx: i, mode: m, oct: o};
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: an event is any cycle with a strobe or with a changed output.
    initial begin
        ev_t cur;
        ev_t prev;
        ev_t want;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = '{strobe: note_strobe, valid: note_valid, idx: note_idx,
                    mode: mode_out, oct: octave};
            if (mon_en && (cur.strobe || (cur[8:0] !== prev[8:0]))) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got=%0h want=none", cur);
                end else begin
                    want = exp_q.pop_front();
                    check("event", 32'(cur), 32'(want));
                end
            end
            prev = cur;
        end
    end

    initial begin
        bit seen;

        // Key held through reset release must register as a fresh press.
        pb[5] = 1'b1;
        cycles(3);
        @(negedge clk);
        check("reset_state", {27'd0, note_strobe, note_valid, note_idx, mode_out, octave}, 32'd0);
        mon_en = 1'b1;
        expect_ev(1, 1, 4'd5, 2'd0, 2'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (note_strobe) seen = 1'b1;
        end
        check("first_strobe_latency", 32'(seen), 32'd1);
        cycles(60);

        expect_ev(0, 0, 4'd5, 2'd0, 2'd0);
        pb[5] = 1'b0;
        cycles(40);

        // Glitch of two samples must not flip anything.
        pb[3] = 1'b1;
        cycles(8);
        pb[3] = 1'b0;
        cycles(40);

        expect_ev(1, 1, 4'd7, 2'd0, 2'd0);
        pb[7] = 1'b1;
        cycles(40);
        expect_ev(1, 1, 4'd2, 2'd0, 2'd0);
        pb[2] = 1'b1;
        cycles(40);
        expect_ev(1, 1, 4'd7, 2'd0, 2'd0);
        pb[2] = 1'b0;
        cycles(40);
        expect_ev(0, 0, 4'd7, 2'd0, 2'd0);
        pb[7] = 1'b0;
        cycles(40);

        for (int n = 1; n <= 5; n++) begin
            expect_ev(0, 0, 4'd7, 2'(n % 4), 2'd0);
            pb[13] = 1'b1;
            cycles(40);
            pb[13] = 1'b0;
            cycles(40);
        end

        for (int n = 1; n <= 4; n++) begin
            expect_ev(0, 0, 4'd7, 2'd1, 2'(n % 3));
            pb[14] = 1'b1;
            cycles(40);
            pb[14] = 1'b0;
            cycles(40);
        end

        // Both buttons in the same cycle: one combined event.
        expect_ev(0, 0, 4'd7, 2'd2, 2'd2);
        pb[14:13] = 2'b11;
        cycles(40);
        pb[14:13] = 2'b00;
        cycles(40);

        // Reset one cycle after a strobe, then re-strobe from the held key.
        expect_ev(1, 1, 4'd9, 2'd2, 2'd2);
        pb[9] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (note_strobe) seen = 1'b1;
        end
        check("strobe_before_reset", 32'(seen), 32'd1);
        @(posedge clk);
        expect_ev(0, 0, 4'd0, 2'd0, 2'd0);
        #1 reset = 1'b1;
        cycles(2);
        check("outputs_after_reset", {27'd0, note_strobe, note_valid, note_idx, mode_out, octave}, 32'd0);
        expect_ev(1, 1, 4'd9, 2'd0, 2'd0);
        reset = 1'b0;
        cycles(60);
        pb[9] = 1'b0;
        expect_ev(0, 0, 4'd9, 2'd0, 2'd0);
        cycles(40);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pb_debounce_encoder.md
PB_DEBOUNCE_ENCODER -- requirements
Module: pb_debounce_encoder

Interface
REQ-001 Parameter SAMPLE_DIV, default 1000: clock cycles per debounce sample tick; legal range 2..65535.
REQ-002 Parameter STABLE_SAMPLES, default 4: consecutive disagreeing samples required to flip a debounced bit; legal range 2..7.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pb  input  15  raw asynchronous pushbuttons, active high; pb[12:0] note keys, pb[13] mode button, pb[14] octave button.
REQ-006 note_idx  output  4  index 0..12 of the selected note key.
REQ-007 note_valid  output  1  high while at least one debounced note key is pressed.
REQ-008 note_strobe  output  1  one-cycle pulse on each new note selection.
REQ-009 mode_out  output  2  synthesizer mode, 0..3.
REQ-010 octave  output  2  octave select, 0..2.

Function
REQ-011 Each pb bit SHALL pass through a two-flop synchronizer before any other use.
REQ-012 A prescaler SHALL count 0..SAMPLE_DIV-1 and wrap to 0; sample_tick SHALL be high for the one cycle in which the count equals SAMPLE_DIV-1.
REQ-013 Each bit SHALL have a 3-bit agreement counter and a debounced state register, with no change on cycles without sample_tick.
REQ-014 On sample_tick, if the synchronized bit equals the debounced bit, that bit's counter SHALL clear to 0.
REQ-015 On sample_tick, if the synchronized bit differs and the counter equals STABLE_SAMPLES-1, the debounced bit SHALL toggle and the counter SHALL clear.
REQ-016 On sample_tick, if the synchronized bit differs and the counter is below STABLE_SAMPLES-1, the counter SHALL increment.
REQ-017 A glitch shorter than STABLE_SAMPLES consecutive samples SHALL never change a debounced bit.
REQ-018 Rising-edge detection SHALL use a registered copy of the debounced vector; an edge SHALL be high for exactly one cycle.
REQ-019 Note encoding SHALL be fixed priority, lowest index wins: note_idx is the lowest set bit of debounced[12:0].
REQ-020 note_valid SHALL be the OR of debounced[12:0].
REQ-021 note_idx and note_valid SHALL be registered, updating one cycle after the debounced vector changes.
REQ-022 When no note key is pressed, note_idx SHALL hold its last value.
REQ-023 note_strobe SHALL pulse in the cycle note_idx/note_valid update if the new note_valid is 1 and either the previous note_valid was 0 or note_idx changed.
REQ-024 Releasing a key SHALL produce no strobe.
REQ-025 Releasing the winning key while a higher index is still held SHALL produce one strobe, with note_idx set to the new winner.
REQ-026 A rising edge of debounced[13] SHALL increment mode_out modulo 4 (3 -> 0).
REQ-027 A rising edge of debounced[14] SHALL increment octave in the sequence 0 -> 1 -> 2 -> 0; octave SHALL never equal 3.
REQ-028 Simultaneous mode and octave edges SHALL both take effect in the same cycle.
REQ-029 Holding a button SHALL cause exactly one increment; auto-repeat is not supported.
REQ-030 All outputs SHALL be registered, with no combinational path from pb to any output.
REQ-031 Worst-case latency from a stable pb change to a debounced flip SHALL be 2 + SAMPLE_DIV*STABLE_SAMPLES cycles.
REQ-032 Outputs SHALL update one cycle after the debounced flip.

Reset
REQ-033 While reset is high at a clk edge, the following SHALL clear to 0: synchronizers, prescaler, agreement counters, debounced vector, edge registers, note_idx, note_valid, note_strobe, mode_out and octave.
REQ-034 Reset asserted mid-debounce or mid-strobe SHALL discard all pending state with no pulse afterward.
REQ-035 A button held through reset release SHALL register as a new press once debounced.

Verification (SAMPLE_DIV=4, STABLE_SAMPLES=4)
REQ-036 Hold pb[5]=1 from reset release -> note_valid=1, note_idx=5, single note_strobe within 2+16+2 cycles; no further strobes while held.
REQ-037 pb[3] high for 8 cycles (2 samples) then low -> note_valid stays 0, no strobe, mode_out/octave unchanged.
REQ-038 Hold pb[7] then add pb[2] -> one strobe, note_idx 7 -> 2; release pb[2] -> one strobe, note_idx=7; release pb[7] -> note_valid=0, note_idx stays 7, no strobe.
REQ-039 Five debounced presses of pb[13] -> mode_out sequence 1,2,3,0,1; four presses of pb[14] -> octave sequence 1,2,0,1.
REQ-040 pb[13] and pb[14] pressed together -> mode_out and octave increment in the same cycle.
REQ-041 Assert reset one cycle after a note_strobe with mode_out=2 -> all outputs 0 next cycle; a still-held key re-strobes after debounce.
